// File: rtl/llr_loader_if.sv
// Upstream LLR beat stream into the loader: valid/ready handshake,
// one beat of Z channel LLRs and an end-of-frame marker.
`ifndef iniBW
`define iniBW 6
`endif

interface llr_loader_if #(
  parameter int Z   = 64,
  parameter int IBW = `iniBW
) ();
  logic             in_valid;
  logic             in_ready;
  logic [Z*IBW-1:0] in_llr;
  logic             in_last;

  modport master (output in_valid, output in_llr, output in_last, input in_ready);
  modport slave  (input in_valid, input in_llr, input in_last, output in_ready);
endinterface

// File: rtl/llr_loader.sv
// Collects COLS beats of Z channel LLRs into the CNU array LLRq layout,
// pulses load_to_CNU once the frame is complete and then holds the buffer
// until the decoder reports it is done with the frame.
//
//   state | meaning
//   IDLE  | out of reset, not yet accepting
//   FILL  | accepting beats into column k
//   LOAD  | one-cycle load pulse to the CNU array
//   BUSY  | frame held for the decoder, waiting for dec_done
`ifndef iniBW
`define iniBW 6
`endif
`ifndef exBW
`define exBW 2
`endif

module llr_loader #(
  localparam int IBW  = `iniBW,
  localparam int EBW  = `exBW,
  localparam int W    = IBW + EBW,
  localparam int Z    = 64,
  localparam int COLS = 27
) (
  input  logic                clk,
  input  logic                rst_n,
  llr_loader_if.slave         s_in,
  input  logic                dec_done,
  output logic                load_to_CNU,
  output logic [Z*W*COLS-1:0] LLRq_init,
  output logic                busy,
  output logic                frame_err
);

  typedef enum logic [1:0] {IDLE, FILL, LOAD, BUSY} state_t;

  localparam logic [4:0] KLAST = 5'(COLS - 1);

  state_t     state, state_nx;
  logic [4:0] k;
  logic       in_ready_q;
  logic       accept;
  logic       frame_end;
  logic       early_last;

  assign s_in.in_ready = in_ready_q;
  assign accept        = s_in.in_valid && in_ready_q;
  assign frame_end     = accept && (k == KLAST);
  assign early_last    = accept && s_in.in_last && (k != KLAST);

  // next-state logic; dec_done only matters while the frame is held
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = FILL;
      FILL: if (frame_end) state_nx = LOAD;
      LOAD: state_nx = BUSY;
      BUSY: if (dec_done) state_nx = FILL;
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // registered outputs decoded from the upcoming state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      load_to_CNU <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      in_ready_q  <= (state_nx == FILL);
      load_to_CNU <= (state_nx == LOAD);
      busy        <= (state_nx == LOAD) || (state_nx == BUSY);
      frame_err   <= early_last || (frame_end && !s_in.in_last);
    end
  end

  // beat counter; restarts on a completed frame or an early in_last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
    end else if (accept) begin
      if (frame_end || early_last) k <= '0;
      else                         k <= k + 5'd1;
    end
  end

  // write every lane of an accepted beat into column k, sign-extended to W;
  // only FILL accepts, so the buffer is frozen through LOAD and BUSY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LLRq_init <= '0;
    end else if (accept) begin
      for (int j = 0; j < Z; j++) begin
        for (int c = 0; c < COLS; c++) begin
          if (k == 5'(c)) begin
            LLRq_init[(j*COLS + c)*W +: W] <=
              {{EBW{s_in.in_llr[j*IBW + IBW - 1]}}, s_in.in_llr[j*IBW +: IBW]};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_llr_loader.sv
// Scoreboard bench for llr_loader: stimulus pushes expected load/error
// events, a monitor pops and compares them whenever the DUT pulses.
`ifndef iniBW
`define iniBW 6
`endif
`ifndef exBW
`define exBW 2
`endif

module tb_llr_loader;
  localparam int Z    = 64;
  localparam int COLS = 27;
  localparam int IBW  = `iniBW;
  localparam int W    = `iniBW + `exBW;
  localparam int FW   = Z * W * COLS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dec_done = 1'b0;
  logic          load_to_CNU;
  logic          busy;
  logic          frame_err;
  logic [FW-1:0] LLRq_init;

  llr_loader_if #(.Z(Z), .IBW(IBW)) bus ();

  llr_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_in        (bus),
    .dec_done    (dec_done),
    .load_to_CNU (load_to_CNU),
    .LLRq_init   (LLRq_init),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic          load;
    logic          err;
    logic [FW-1:0] frame;
    int            cyc;
  } exp_t;

  exp_t          expq[$];
  int            checks = 0;
  int            errors = 0;
  logic [FW-1:0] mdl = '0;
  int            mk = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_frame(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < Z*COLS; i++) begin
        if (act[i*W +: W] !== exp[i*W +: W]) begin
          $display("FAIL %s: lane %0d col %0d got %h expected %h (cycle %0d)",
                   name, i / COLS, i % COLS, act[i*W +: W], exp[i*W +: W], cyc);
          break;
        end
      end
    end
  endtask

  function automatic logic [W-1:0] sext(input logic [IBW-1:0] v);
    logic signed [IBW-1:0] s;
    logic signed [W-1:0]   r;
    s = v;
    r = s;
    return r;
  endfunction

  function automatic logic [Z*IBW-1:0] ramp(input int k);
    logic [Z*IBW-1:0] d;
    for (int j = 0; j < Z; j++) d[j*IBW +: IBW] = IBW'(j + k);
    return d;
  endfunction

  // reference framing model, run on each accepted beat
  task automatic model_accept(input logic [Z*IBW-1:0] d, input logic last);
    exp_t e;
    for (int j = 0; j < Z; j++) mdl[(j*COLS + mk)*W +: W] = sext(d[j*IBW +: IBW]);
    if (mk == COLS - 1) begin
      e.load = 1'b1; e.err = !last; e.frame = mdl; e.cyc = cyc;
      expq.push_back(e);
      mk = 0;
    end else if (last) begin
      e.load = 1'b0; e.err = 1'b1; e.frame = '0; e.cyc = cyc;
      expq.push_back(e);
      mk = 0;
    end else begin
      mk++;
    end
  endtask

  task automatic send_beat(input logic [Z*IBW-1:0] d, input logic last);
    bit acc = 0;
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_llr   = d;
    bus.in_last  = last;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: no in_ready after %0d cycles expected accept", n);
        bus.in_valid = 1'b0;
        return;
      end
    end
    model_accept(d, last);
  endtask

  task automatic send_frame(input int off, input int nbeats, input int last_at,
                            input bit ones, input bit gaps, input int dd_at);
    logic [Z*IBW-1:0] d;
    for (int k = 0; k < nbeats; k++) begin
      d = ones ? {Z*IBW{1'b1}} : ramp(off + k);
      if (k == dd_at) dec_done = 1'b1;
      send_beat(d, k == last_at);
      dec_done = 1'b0;
      if (gaps && k < nbeats - 1) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic dec_release();
    repeat (2) begin
      @(negedge clk);
      chk1("ready_low_held", bus.in_ready, 1'b0);
      chk1("busy_held", busy, 1'b1);
    end
    @(posedge clk);
    #1 dec_done = 1'b1;
    @(negedge clk);
    chk1("ready_low_dec_cycle", bus.in_ready, 1'b0);
    @(posedge clk);
    #1 dec_done = 1'b0;
    chk1("ready_after_dec", bus.in_ready, 1'b1);
    chk1("busy_after_dec", busy, 1'b0);
    chki("queue_drained", expq.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_ready"}, bus.in_ready, 1'b0);
    chk1({tag, "_load"}, load_to_CNU, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_err"}, frame_err, 1'b0);
    chk_frame({tag, "_buffer"}, LLRq_init, '0);
  endtask

  // monitor: every load/error pulse must match the next expected event
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (load_to_CNU || frame_err)) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: load=%0b err=%0b expected no event (cycle %0d)",
                   load_to_CNU, frame_err, cyc);
        end else begin
          e = expq.pop_front();
          chk1("event_load", load_to_CNU, e.load);
          chk1("event_err", frame_err, e.err);
          chki("event_latency", cyc, e.cyc);
          if (e.load) chk_frame("frame_data", LLRq_init, e.frame);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] snap;
    bus.in_valid = 1'b0;
    bus.in_llr   = '0;
    bus.in_last  = 1'b0;

    // reset state
    #2;
    @(negedge clk);
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk1("ready_idle", bus.in_ready, 1'b0);
    @(posedge clk);
    #1 chk1("ready_fill", bus.in_ready, 1'b1);

    // ramp frame, dec_done during FILL and LOAD ignored, then held in BUSY
    send_frame(0, COLS, COLS - 1, 1'b0, 1'b0, 10);
    dec_done = 1'b1;
    @(posedge clk);
    #1 dec_done = 1'b0;
    snap = mdl;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_llr   = {12{$urandom()}};
    repeat (100) begin
      @(negedge clk);
      chk1("busy_hold_ready", bus.in_ready, 1'b0);
      chk1("busy_hold_busy", busy, 1'b1);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    chk_frame("busy_hold_frame", LLRq_init, snap);
    dec_release();

    // all -1 LLRs with random gaps
    send_frame(0, COLS, COLS - 1, 1'b1, 1'b1, -1);
    @(negedge clk);
    chk_frame("all_ones", LLRq_init, {FW{1'b1}});
    chk1("all_ones_err", frame_err, 1'b0);
    dec_release();

    // early in_last on beat 5, then a good frame
    send_frame(5, 6, 5, 1'b0, 1'b0, -1);
    @(posedge clk);
    #1;
    send_frame(7, COLS, COLS - 1, 1'b0, 1'b0, -1);
    dec_release();

    // missing in_last on beat 26: error and load together
    send_frame(20, COLS, -1, 1'b0, 1'b0, -1);
    dec_release();

    // reset mid-fill at beat 13, then a full frame
    send_frame(3, 13, -1, 1'b0, 1'b0, -1);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midfill_reset");
    mk = 0;
    mdl = '0;
    expq.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    send_frame(11, COLS, COLS - 1, 1'b0, 1'b0, -1);

    // reset while the frame is held
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midbusy_reset");
    mk = 0;
    mdl = '0;
    expq.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk1("after_busy_reset_ready", bus.in_ready, 1'b1);
    chk1("after_busy_reset_busy", busy, 1'b0);

    repeat (5) @(posedge clk);
    #1 chki("final_queue_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
